alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_pkg.sv | 25 ++
 rtl/mdu_sign_ctrl.sv | 75 +++++++
 rtl/alu_mdu.sv | 158 +++++++++++++++
 tb/tb_alu_mdu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation and state types for the multiply/divide unit
package alu_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU});
  endfunction

endpackage

// File: rtl/mdu_sign_ctrl.sv
// rtl/mdu_sign_ctrl.sv - operand magnitudes and final sign correction (combinational)
module mdu_sign_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] result
);

  logic                   sign_a;
  logic                   sign_b;
  logic                   neg_prod;
  logic                   neg_quo;
  logic                   neg_rem;
  logic [WIDTH-1:0]       abs_a;
  logic [WIDTH-1:0]       abs_b;
  logic [2*WIDTH-1:0]     prod;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix;
  logic [WIDTH-1:0]       rem_fix;

  // Pick unsigned magnitudes for the iterative core and fold the signs back into the raw result
  always_comb begin
    sign_a   = a[WIDTH-1];
    sign_b   = b[WIDTH-1];
    abs_a    = sign_a ? -a : a;
    abs_b    = sign_b ? -b : b;
    a_mag    = a;
    b_mag    = b;
    neg_prod = 1'b0;
    neg_quo  = 1'b0;
    neg_rem  = 1'b0;
    case (op)
      MD_MULH: begin
        a_mag    = abs_a;
        b_mag    = abs_b;
        neg_prod = sign_a ^ sign_b;
      end
      MD_MULHSU: begin
        a_mag    = abs_a;
        neg_prod = sign_a;
      end
      MD_DIV: begin
        a_mag   = abs_a;
        b_mag   = abs_b;
        // a zero divisor must leave the all-ones quotient untouched
        neg_quo = (sign_a ^ sign_b) && (b != '0);
      end
      MD_REM: begin
        a_mag   = abs_a;
        b_mag   = abs_b;
        neg_rem = sign_a;
      end
      default: ;
    endcase
    prod     = {hi, lo};
    prod_fix = neg_prod ? -prod : prod;
    quo_fix  = neg_quo ? -lo : lo;
    rem_fix  = neg_rem ? -hi : hi;
    case (op)
      MD_MUL:                       result = prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - radix-2 multiply/divide unit; MDU_FAST_SPECIAL_EN short-cuts divide special cases
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_md_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_md_data
);

  localparam int             CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

  mdu_state_e       state;
  md_op_e           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] md_data_q;
  logic [CW-1:0]    cnt_q;

  md_op_e           op_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;
  logic             div_s;

  // In IDLE the sign helper looks at the live request, afterwards at the latched one
  always_comb begin
    op_s  = (state == MDU_IDLE) ? md_op_e'(i_md_op) : op_q;
    a_s   = (state == MDU_IDLE) ? i_operand_a : a_q;
    b_s   = (state == MDU_IDLE) ? i_operand_b : b_q;
    div_s = op_is_div(op_s);
  end

  mdu_sign_ctrl #(
    .WIDTH (WIDTH)
  ) u_sign_ctrl (
    .op     (op_s),
    .a      (a_s),
    .b      (b_s),
    .hi     (next_hi),
    .lo     (next_lo),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .result (result)
  );

  // One iteration: shift-add multiply on {hi,lo}, or restoring divide with hi as partial remainder
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, m_q});
    diff    = shifted[WIDTH-1:0] - m_q;
    if (op_is_div(op_q)) begin
      next_hi = ge ? diff : shifted[WIDTH-1:0];
      next_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

`ifdef MDU_FAST_SPECIAL_EN
  logic             special;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_data;

  // Divide-by-zero and signed overflow have fixed answers that need no iterations
  always_comb begin
    div_zero = (i_operand_b == '0);
    overflow = (md_op_e'(i_md_op) inside {MD_DIV, MD_REM})
               && (i_operand_a == {1'b1, {(WIDTH-1){1'b0}}})
               && (i_operand_b == '1);
    special  = op_is_div(md_op_e'(i_md_op)) && (div_zero || overflow);
    if (div_zero) special_data = i_md_op[1] ? i_operand_a : '1;
    else          special_data = i_md_op[1] ? '0 : i_operand_a;
  end
`endif

  // Control FSM and datapath registers; flush and reset both drop the request silently
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= MDU_IDLE;
      op_q      <= MD_MUL;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      md_data_q <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (i_valid && !i_flush) begin
            op_q  <= md_op_e'(i_md_op);
            a_q   <= i_operand_a;
            b_q   <= i_operand_b;
            m_q   <= div_s ? b_mag : a_mag;
            lo_q  <= div_s ? a_mag : b_mag;
            hi_q  <= '0;
            cnt_q <= '0;
`ifdef MDU_FAST_SPECIAL_EN
            if (special) begin
              md_data_q <= special_data;
              state     <= MDU_DONE;
            end else begin
              state <= MDU_BUSY;
            end
`else
            state <= MDU_BUSY;
`endif
          end
        end
        MDU_BUSY: begin
          if (i_flush) begin
            state <= MDU_IDLE;
          end else begin
            hi_q  <= next_hi;
            lo_q  <= next_lo;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
              md_data_q <= result;
              state     <= MDU_DONE;
            end
          end
        end
        MDU_DONE: state <= MDU_IDLE;
        default:  state <= MDU_IDLE;
      endcase
    end
  end

  assign o_ready   = (state == MDU_IDLE);
  assign o_valid   = (state == MDU_DONE);
  assign o_md_data = md_data_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu against an arithmetic reference model
module tb_alu_mdu;

  localparam int W = 32;
`ifdef MDU_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          flush;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          rdy;
  logic          vld;
  logic [W-1:0]  data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .o_ready     (rdy),
    .i_md_op     (op),
    .i_operand_a (a),
    .i_operand_b (b),
    .i_flush     (flush),
    .o_valid     (vld),
    .o_md_data   (data)
  );

  logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'(uy); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && (y == 0 || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Called one time unit after a rising edge; returns at the same phase, one cycle after the result
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp);
    int n;
    int lat;
    int exp_lat;
    exp_lat = (FAST && is_special(o, x, y)) ? 1 : W + 1;
    n = 0;
    while (!rdy && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, "_ready"}, rdy, 1'b1);
    valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!vld && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, "_valid"}, vld, 1'b1);
    check({tag, "_data"}, data, exp);
    check({tag, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
    check({tag, "_pulse"}, vld, 1'b0);
    check({tag, "_idle"}, rdy, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rdy, 1'b1);
    check("rst_valid", vld, 1'b0);
    check("rst_data", data, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], d_exp[i]);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       x = 32'h8000_0000;
        1:       x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = $urandom_range(1, 16);
        default: y = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, o), o, x, y, ref_md(o, x, y));
    end

    valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    check("flush_noaccept", rdy, 1'b1);

    valid = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy", rdy, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", rdy, 1'b1);
    check("flush_valid", vld, 1'b0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (vld) seen = 1'b1; end
    check("flush_quiet", seen, 1'b0);

    valid = 1'b1; op = 3'd4; a = $urandom; b = 32'd3;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("rstmid_busy", rdy, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_ready", rdy, 1'b1);
    check("rstmid_valid", vld, 1'b0);
    check("rstmid_data", data, 32'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (vld) seen = 1'b1; end
    check("rstmid_quiet", seen, 1'b0);

    begin
      logic [2:0]  q_op [3];
      logic [31:0] q_a  [3];
      logic [31:0] q_b  [3];
      int          acc_cyc[$];
      logic [31:0] exp_q[$];
      int          idx, got, budget;
      bit          inflight, prev_v;
      q_op[0] = 3'd3; q_op[1] = 3'd5; q_op[2] = 3'd6;
      for (int i = 0; i < 3; i++) begin
        q_a[i] = $urandom;
        q_b[i] = $urandom_range(2, 1000);
      end
      idx = 0; got = 0; budget = 0; inflight = 1'b0; prev_v = 1'b0;
      valid = 1'b1; op = q_op[0]; a = q_a[0]; b = q_b[0];
      while (got < 3 && budget < 300) begin
        bit acc_now;
        acc_now = rdy && valid;
        @(posedge clk); #1;
        budget++;
        if (acc_now) begin
          acc_cyc.push_back(budget);
          exp_q.push_back(ref_md(op, a, b));
          inflight = 1'b1;
          idx++;
          if (idx < 3) begin
            op = q_op[idx]; a = q_a[idx]; b = q_b[idx];
          end else begin
            valid = 1'b0;
          end
        end
        check("b2b_ready", rdy, !inflight);
        if (prev_v) check("b2b_pulse", vld, 1'b0);
        if (vld) begin
          if (exp_q.size() > 0) check($sformatf("b2b_data%0d", got), data, exp_q.pop_front());
          else check("b2b_unexpected_valid", vld, 1'b0);
          inflight = 1'b0;
          got++;
        end
        prev_v = vld;
      end
      valid = 1'b0;
      check("b2b_results", got, 3);
      check("b2b_accepts", acc_cyc.size(), 3);
      for (int i = 1; i < acc_cyc.size(); i++) check($sformatf("b2b_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], W + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
